csi2_delay_calib: RTL

CSI2_DELAY_CALIB -- requirements
Module: csi2_delay_calib

---
 rtl/csi2_calib_pkg.sv | 32 +++
 rtl/csi2_eye_tracker.sv | 63 ++++++
 rtl/csi2_delay_calib.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/csi2_calib_pkg.sv
// Shared types and constants for the CSI-2 receiver delay calibration block.
// Combinational helpers only; no latency, no flow control.
package csi2_calib_pkg;

  localparam int TAP_W = 5;
  localparam int RUN_W = TAP_W + 1;
  localparam logic [TAP_W-1:0] TAP_MAX = 5'd31;
  localparam logic [RUN_W-1:0] RUN_MAX = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_NEXT_LANE,
    ST_APPLY,
    ST_DONE
  } state_t;

  // Floor centre of a passing window; a window never extends past TAP_MAX,
  // the clamp only guards against a corrupted length.
  function automatic logic [TAP_W-1:0] eye_center(input logic [TAP_W-1:0] start,
                                                  input logic [RUN_W-1:0] len);
    logic [RUN_W-1:0] half;
    logic [RUN_W-1:0] sum;
    half = (len - RUN_W'(1)) >> 1;
    sum  = {1'b0, start} + half;
    return (sum > {1'b0, TAP_MAX}) ? TAP_MAX : sum[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/csi2_eye_tracker.sv
// Tracks the current and longest run of passing taps for one lane sweep.
// Updates one cycle after upd_i; centre/found are combinational from registers; no backpressure.
module csi2_eye_tracker
  import csi2_calib_pkg::*;
(
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             clr_i,
  input  logic             upd_i,
  input  logic             pass_i,
  input  logic [TAP_W-1:0] tap_i,
  output logic             found_o,
  output logic [TAP_W-1:0] center_o
);

  logic [TAP_W-1:0] cur_start_q, cur_start_d;
  logic [TAP_W-1:0] best_start_q, best_start_d;
  logic [RUN_W-1:0] cur_len_q, cur_len_d;
  logic [RUN_W-1:0] best_len_q, best_len_d;

  always_comb begin
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (clr_i) begin
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (upd_i) begin
      if (pass_i) begin
        if (cur_len_q == '0) cur_start_d = tap_i;
        if (cur_len_q != RUN_MAX) cur_len_d = cur_len_q + RUN_W'(1);
        // Strictly greater: on a tie the earlier window is kept.
        if (cur_len_d > best_len_q) begin
          best_start_d = cur_start_d;
          best_len_d   = cur_len_d;
        end
      end else begin
        cur_len_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign found_o  = (best_len_q != '0);
  assign center_o = eye_center(best_start_q, best_len_q);

endmodule

// File: rtl/csi2_delay_calib.sv
// Sweeps every IDELAY tap per lane, scores each by packet errors, and applies the eye centre.
// Run takes LANES*(32*(SETTLE+WINDOW+2)+1)+3 cycles start-to-done; inputs are pulses, never stalled.
module csi2_delay_calib
  import csi2_calib_pkg::*;
#(
  parameter int DATA_LANES    = 2,
  parameter int SETTLE_CYCLES = 256,
  parameter int WINDOW_CYCLES = 65536,
  parameter int MIN_PKTS      = 4,
  parameter int DEFAULT_TAP   = 16
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic                        header_err_i,
  input  logic                        crc_err_i,
  input  logic                        pkt_ok_i,
  output logic                        phy_en_o,
  output logic                        delay_act_o,
  output logic [DATA_LANES*TAP_W-1:0] lane_delay_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [DATA_LANES-1:0]       fail_o
);

  localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LANE_W  = (DATA_LANES > 1) ? $clog2(DATA_LANES) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(DATA_LANES - 1);
  localparam logic [TAP_W-1:0]  DEF_TAP     = TAP_W'(DEFAULT_TAP);
  localparam logic [15:0]       PKT_MIN     = 16'(MIN_PKTS);

  state_t                               state_q;
  logic [LANE_W-1:0]                    lane_q;
  logic [TAP_W-1:0]                     tap_q;
  logic [CNT_W-1:0]                     cnt_q;
  logic                                 err_q;
  logic [15:0]                          pkt_q;
  logic [DATA_LANES-1:0][TAP_W-1:0]     dly_q;
  logic [DATA_LANES-1:0]                fail_q;
  logic                                 phy_en_q;
  logic                                 act_q;
  logic                                 busy_q;
  logic                                 done_q;

  logic             tap_pass;
  logic             trk_clr;
  logic             trk_upd;
  logic             trk_found;
  logic [TAP_W-1:0] trk_center;

  assign tap_pass = !err_q && (pkt_q >= PKT_MIN);
  // Idle clearing also discards any partial sweep left behind by an abort.
  assign trk_clr  = (state_q == ST_IDLE) || (state_q == ST_NEXT_LANE);
  assign trk_upd  = (state_q == ST_EVAL);

  csi2_eye_tracker u_eye (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .clr_i    (trk_clr),
    .upd_i    (trk_upd),
    .pass_i   (tap_pass),
    .tap_i    (tap_q),
    .found_o  (trk_found),
    .center_o (trk_center)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= ST_IDLE;
      lane_q   <= '0;
      tap_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      pkt_q    <= '0;
      dly_q    <= {DATA_LANES{DEF_TAP}};
      fail_q   <= '0;
      phy_en_q <= 1'b0;
      act_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      act_q  <= 1'b0;
      done_q <= 1'b0;
      if (abort_i && state_q != ST_IDLE) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        dly_q    <= {DATA_LANES{DEF_TAP}};
        act_q    <= 1'b1;
        busy_q   <= 1'b0;
        phy_en_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i && !abort_i) begin
              fail_q    <= '0;
              phy_en_q  <= 1'b1;
              lane_q    <= '0;
              tap_q     <= '0;
              dly_q[0]  <= '0;
              act_q     <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            pkt_q   <= '0;
            state_q <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_MEASURE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_MEASURE: begin
            if (header_err_i || crc_err_i) err_q <= 1'b1;
            if (pkt_ok_i && pkt_q != 16'hFFFF) pkt_q <= pkt_q + 16'd1;
            if (cnt_q == WINDOW_LAST) begin
              cnt_q   <= '0;
              state_q <= ST_EVAL;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_EVAL: begin
            if (tap_q == TAP_MAX) begin
              state_q <= ST_NEXT_LANE;
            end else begin
              tap_q         <= tap_q + TAP_W'(1);
              dly_q[lane_q] <= tap_q + TAP_W'(1);
              act_q         <= 1'b1;
              state_q       <= ST_LOAD;
            end
          end
          ST_NEXT_LANE: begin
            if (!trk_found) begin
              fail_q[lane_q] <= 1'b1;
              dly_q[lane_q]  <= DEF_TAP;
            end else begin
              dly_q[lane_q]  <= trk_center;
            end
            act_q <= 1'b1;
            if (lane_q == LANE_LAST) begin
              state_q <= ST_APPLY;
            end else begin
              lane_q                     <= lane_q + LANE_W'(1);
              tap_q                      <= '0;
              dly_q[lane_q + LANE_W'(1)] <= '0;
              state_q                    <= ST_LOAD;
            end
          end
          ST_APPLY: begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign phy_en_o     = phy_en_q;
  assign delay_act_o  = act_q;
  assign lane_delay_o = dly_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fail_o       = fail_q;

endmodule
